smi_request_scheduler: RTL

//  Shares one SMI request/response port pair (the AXI bus adaptor's smiReq*/smiResp*) between NumPorts requesters.

---
 rtl/smi_request_scheduler_pkg.sv | 22 ++
 rtl/smi_request_scheduler_if.sv | 45 ++++
 rtl/smi_owner_fifo.sv | 50 +++++
 rtl/smi_request_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/smi_request_scheduler_pkg.sv
// Shared SMI definitions: EOFC width, last-flit test, frame type ids and scheduler state encoding.
package smi_request_scheduler_pkg;

    localparam int EofcWidth = 8;

    localparam logic [7:0] FrameTypeWrite = 8'h01;
    localparam logic [7:0] FrameTypeRead  = 8'h02;
    localparam logic [7:0] FrameTypeMask  = 8'hFF;

    typedef logic [EofcWidth-1:0] eofc_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } reqState_e;

    // Any non-zero EOFC carries the byte count of the final flit.
    function automatic logic isLastFlit(input eofc_t eofc);
        return eofc != '0;
    endfunction

endpackage

// File: rtl/smi_request_scheduler_if.sv
// SMI request/response links between NumPorts clients, the scheduler and the bus adaptor.
// slave = scheduler side, master = the clients/adaptor driving it.
interface smi_request_scheduler_if #(
    parameter int DataIndexSize = 4,
    parameter int NumPorts      = 4
);
    import smi_request_scheduler_pkg::*;

    localparam int FlitBits = (1 << DataIndexSize) * 8;

    logic [NumPorts-1:0]               reqInReady;
    eofc_t [NumPorts-1:0]              reqInEofc;
    logic [NumPorts-1:0][FlitBits-1:0] reqInData;
    logic [NumPorts-1:0]               reqInStop;

    logic                              reqOutReady;
    eofc_t                             reqOutEofc;
    logic [FlitBits-1:0]               reqOutData;
    logic                              reqOutStop;

    logic                              respInReady;
    eofc_t                             respInEofc;
    logic [FlitBits-1:0]               respInData;
    logic                              respInStop;

    logic [NumPorts-1:0]               respOutReady;
    eofc_t                             respOutEofc;
    logic [FlitBits-1:0]               respOutData;
    logic [NumPorts-1:0]               respOutStop;

    modport slave (
        input  reqInReady, reqInEofc, reqInData, reqOutStop,
        input  respInReady, respInEofc, respInData, respOutStop,
        output reqInStop, reqOutReady, reqOutEofc, reqOutData,
        output respInStop, respOutReady, respOutEofc, respOutData
    );

    modport master (
        output reqInReady, reqInEofc, reqInData, reqOutStop,
        output respInReady, respInEofc, respInData, respOutStop,
        input  reqInStop, reqOutReady, reqOutEofc, reqOutData,
        input  respInStop, respOutReady, respOutEofc, respOutData
    );

endinterface

// File: rtl/smi_owner_fifo.sv
// Purpose: records the requester index of each granted frame, oldest at front.
// Latency: push visible at front/count one cycle later; front is a combinational read.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop keeps count.
module smi_owner_fifo #(
    parameter int Width     = 2,
    parameter int Depth     = 16,
    parameter int IndexSize = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 push,
    input  logic [Width-1:0]     pushData,
    input  logic                 pop,
    output logic [Width-1:0]     front,
    output logic [IndexSize:0]   count,
    output logic                 full,
    output logic                 empty
);

    logic [Width-1:0]     mem [Depth];
    logic [IndexSize-1:0] wrPtr;
    logic [IndexSize-1:0] rdPtr;
    logic                 doPush;
    logic                 doPop;

    assign full   = (count == (IndexSize+1)'(Depth));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign front  = mem[rdPtr];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/smi_request_scheduler.sv
// Purpose: round-robin, frame-atomic sharing of one SMI request/response port pair among NumPorts clients.
// Latency: one IDLE grant cycle before each frame, then flits pass combinationally; responses pass combinationally.
// Backpressure: reqOutStop/respOutStop forwarded to the owning client; non-owners and a full owner FIFO see Stop=1.
module smi_request_scheduler
    import smi_request_scheduler_pkg::*;
#(
    parameter int DataIndexSize     = 4,
    parameter int NumPorts          = 4,
    parameter int PortIndexSize     = 2,
    parameter int MaxInFlight       = 16,
    parameter int InFlightIndexSize = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    smi_request_scheduler_if.slave     bus,
    output logic [InFlightIndexSize:0] inFlight,
    output logic                       orphanResp
);

    localparam int FlitBits = (1 << DataIndexSize) * 8;
    localparam logic [PortIndexSize-1:0] LastPort = PortIndexSize'(NumPorts - 1);

    reqState_e                state;
    reqState_e                stateNext;
    logic [PortIndexSize-1:0] rrPtr;
    logic [PortIndexSize-1:0] rrPtrNext;
    logic [PortIndexSize-1:0] grantIdx;
    logic [PortIndexSize-1:0] pickIdx;
    logic [PortIndexSize-1:0] cand;
    logic [PortIndexSize-1:0] headIdx;
    logic                     pickVld;
    logic                     reqVld;
    logic                     reqXfer;
    logic                     respXfer;
    logic                     fifoPush;
    logic                     fifoPop;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic [FlitBits-1:0]      reqSelData;

    // First requesting port at or after rrPtr, wrapping.
    always_comb begin
        pickVld = 1'b0;
        pickIdx = '0;
        cand    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = PortIndexSize'((int'(rrPtr) + i) % NumPorts);
            if (!pickVld && bus.reqInReady[cand]) begin
                pickVld = 1'b1;
                pickIdx = cand;
            end
        end
    end

    always_comb begin
        stateNext     = state;
        rrPtrNext     = rrPtr;
        fifoPush      = 1'b0;
        reqVld        = 1'b0;
        reqXfer       = 1'b0;
        bus.reqInStop = '1;
        case (state)
            IDLE: begin
                if (pickVld && !fifoFull) begin
                    fifoPush  = 1'b1;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                reqVld                  = bus.reqInReady[grantIdx];
                bus.reqInStop[grantIdx] = bus.reqOutStop;
                reqXfer                 = reqVld && !bus.reqOutStop;
                if (reqXfer && isLastFlit(bus.reqInEofc[grantIdx])) begin
                    rrPtrNext = (grantIdx == LastPort) ? '0 : grantIdx + 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign reqSelData      = bus.reqInData[grantIdx];
    assign bus.reqOutReady = reqVld;
    assign bus.reqOutEofc  = bus.reqInEofc[grantIdx];
    assign bus.reqOutData  = reqSelData;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            rrPtr      <= '0;
            grantIdx   <= '0;
            orphanResp <= 1'b0;
        end else begin
            state <= stateNext;
            rrPtr <= rrPtrNext;
            if (fifoPush) grantIdx <= pickIdx;
            if (fifoEmpty && bus.respInReady) orphanResp <= 1'b1;
        end
    end

    // Responses come back in grant order, so the FIFO head names their owner.
    always_comb begin
        bus.respOutReady = '0;
        bus.respInStop   = 1'b1;
        respXfer         = 1'b0;
        if (!fifoEmpty) begin
            bus.respOutReady[headIdx] = bus.respInReady;
            bus.respInStop            = bus.respOutStop[headIdx];
            respXfer                  = bus.respInReady && !bus.respOutStop[headIdx];
        end
    end

    assign fifoPop         = respXfer && isLastFlit(bus.respInEofc);
    assign bus.respOutEofc = bus.respInEofc;
    assign bus.respOutData = bus.respInData;

    smi_owner_fifo #(
        .Width     (PortIndexSize),
        .Depth     (MaxInFlight),
        .IndexSize (InFlightIndexSize)
    ) ownerFifo (
        .clk      (clk),
        .resetN   (resetN),
        .push     (fifoPush),
        .pushData (pickIdx),
        .pop      (fifoPop),
        .front    (headIdx),
        .count    (inFlight),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

endmodule
